codec_cfg_arbiter: RTL and testbench
====================================

// Module: codec_cfg_arbiter
// PURPOSE
//  Sole master of the i2c_seq_sm CODEC register interface (codec_rd_en/codec_wr_en handshake).
//  After reset, replays an SSM2603 init table from an external ROM.
//  Then round-robin arbitrates register RD/WR requests from two clients (0: PS/AXI regs, 1: volume ctrl).
//  Detects missed ACKs and stalled transfers, and reports them per transaction.
// PARAMETERS
//  INIT_LEN       10     number of init table entries (1..16)
//  POR_DELAY      1000   clk cycles to wait after reset release before the first init write
//  START_WAIT     4      max cycles from enable pulse to controller_busy rising
//  XFER_TIMEOUT   65535  max cycles controller_busy may stay high per transaction
// PORTS
//  clk                  in   1   system clock
//  reset                in   1   asynchronous, active-low reset
//  init_start           in   1   pulse: rerun the init table
//  init_done            out  1   init table completed (level)
//  init_error           out  1   sticky: any init entry NACKed or timed out; cleared on init start
//  init_rom_addr        out  4   init table index
//  init_rom_data        in   16  {reg_addr[15:8], data[7:0]}; valid 1 cycle after addr; reg_addr 8'hFF = end
//  req_rd               in   2   per-client read request, level, held until req_done
//  req_wr               in   2   per-client write request, level; rd&wr both set = write
//  req_addr             in   16  {client1[15:8], client0[7:0]} CODEC register address
//  req_wdata            in   16  {client1[15:8], client0[7:0]} write data
//  req_done             out  2   1-cycle pulse to the granted client when its transaction ends
//  req_rdata            out  8   read data, valid with req_done
//  req_err              out  1   valid with req_done: NACK or timeout
//  codec_rd_en          out  1   1-cycle read-start pulse to i2c_seq_sm
//  codec_wr_en          out  1   1-cycle write-start pulse
//  codec_reg_addr       out  8   register address, held stable while busy
//  codec_data_in        out  8   write data, held stable while busy
//  codec_data_out       in   8   read data from i2c_seq_sm
//  codec_data_out_valid in   1   read data valid (level)
//  controller_busy      in   1   i2c_seq_sm busy
//  missed_ack           in   1   NACK status of last transfer
// BEHAVIOUR
//  Reset values
//   - All outputs 0; init_rom_addr 0; state POR_WAIT; RR pointer 0; counters 0.
//   - Reset mid-transfer aborts with no req_done.
//  States
//   - POR_WAIT: count POR_DELAY cycles, then go to FETCH.
//   - FETCH: drive init_rom_addr = idx; wait 1 cycle; latch init_rom_data.
//     - reg_addr==8'hFF or idx==INIT_LEN: go to IDLE and set init_done.
//     - Otherwise go to ISSUE as a write.
//   - IDLE: service a latched init_start first (clear init_done and init_error, idx=0, go to FETCH). Otherwise arbitrate.
//   - ISSUE: wait for controller_busy==0.
//     - Then pulse codec_rd_en or codec_wr_en for exactly 1 cycle.
//     - Drive codec_reg_addr/codec_data_in from the same cycle until DONE.
//   - WAIT_HI: wait for controller_busy==1.
//     - If still low after START_WAIT cycles: error and go to DONE.
//   - WAIT_LO: wait for controller_busy==0, capturing codec_data_out when codec_data_out_valid.
//     - Error if busy stays high XFER_TIMEOUT cycles, or if missed_ack==1 when busy falls.
//   - DONE (1 cycle):
//     - Init entry: OR the error into init_error, idx++, go to FETCH. Init continues past errors.
//     - Client: pulse req_done[g] with req_rdata/req_err, go to IDLE.
//  Arbitration
//   - Only in IDLE with init_done=1; requests arriving during init are held.
//   - Round-robin: grant the client != last grant when both request; a lone requester is granted every time.
//   - Grant, addr and data are latched at grant.
//   - Client deasserting its request mid-transfer does not abort it.
//  Timing
//   - Write latency = ISSUE->DONE.
//   - Back-to-back transactions have >=1 IDLE/FETCH cycle between DONE and the next enable.
//   - codec_rd_en and codec_wr_en are never high together.
//   - init_start while busy is latched and runs after the current transaction.
//   - Counters saturate; no wrap.
//  req_rdata
//   - Holds its last value.
//   - 0 for writes.
// TESTING
//  - Reset, ROM of 3 entries then 8'hFF, model ACKs, busy 20 cycles -> 3 wr pulses at addrs from ROM after POR_DELAY; init_done=1, init_error=0.
//  - Client0 read addr 8'h07, model returns 8'h0A -> codec_rd_en 1 pulse, req_done=2'b01, req_rdata=8'h0A, req_err=0.
//  - Both clients write continuously -> grants alternate 0,1,0,1; each req_done one-hot.
//  - Model sets missed_ack on init entry 2 -> init_error=1, entry 3 still issued, init_done=1.
//  - Busy never rises (START_WAIT=4) -> req_err=1 with req_done 6 cycles after enable; busy stuck -> err after XFER_TIMEOUT.
//  - Reset asserted mid-WAIT_LO -> all outputs 0 asynchronously; no req_done; init rerun after release.

Source files
------------

// File: rtl/codec_cfg_arbiter.sv
// Sole master of the i2c_seq_sm register port: replays the init ROM after reset, then round-robins client RD/WR.
// One transaction in flight; clients hold level requests until their req_done pulse, init_start is queued until IDLE.
module codec_cfg_arbiter #(
  parameter int INIT_LEN     = 10,
  parameter int POR_DELAY    = 1000,
  parameter int START_WAIT   = 4,
  parameter int XFER_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_start,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  init_rom_addr,
  input  logic [15:0] init_rom_data,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  req_done,
  output logic [7:0]  req_rdata,
  output logic        req_err,
  output logic        codec_rd_en,
  output logic        codec_wr_en,
  output logic [7:0]  codec_reg_addr,
  output logic [7:0]  codec_data_in,
  input  logic [7:0]  codec_data_out,
  input  logic        codec_data_out_valid,
  input  logic        controller_busy,
  input  logic        missed_ack
);

  localparam int MAX_A = (XFER_TIMEOUT > POR_DELAY) ? XFER_TIMEOUT : POR_DELAY;
  localparam int MAX_V = (MAX_A > START_WAIT) ? MAX_A : START_WAIT;
  localparam int CW    = $clog2(MAX_V + 2);
  localparam logic [CW-1:0] POR_LIM = CW'(POR_DELAY - 1);
  localparam logic [CW-1:0] SW_LIM  = CW'(START_WAIT);
  localparam logic [CW-1:0] TO_LIM  = CW'(XFER_TIMEOUT);
  localparam logic [4:0]    LEN     = 5'(INIT_LEN);

  typedef enum logic [2:0] {
    S_POR, S_FETCH, S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          fetch_ph;
  logic [4:0]    idx;
  logic          init_pend;
  logic          gnt;
  logic          last_gnt;
  logic [7:0]    cur_addr;
  logic [7:0]    cur_data;
  logic          cur_wr;
  logic          cur_init;
  logic          err;
  logic [7:0]    rdata_q;

  logic [1:0]    req_any;
  logic          pick;
  logic [4:0]    idx_nxt;

  assign req_any = req_rd | req_wr;
  assign pick    = (req_any == 2'b11) ? ~last_gnt : req_any[1];
  assign idx_nxt = idx + 5'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_POR;
      cnt            <= '0;
      fetch_ph       <= 1'b0;
      idx            <= '0;
      init_pend      <= 1'b0;
      gnt            <= 1'b0;
      last_gnt       <= 1'b0;
      cur_addr       <= '0;
      cur_data       <= '0;
      cur_wr         <= 1'b0;
      cur_init       <= 1'b0;
      err            <= 1'b0;
      rdata_q        <= '0;
      init_done      <= 1'b0;
      init_error     <= 1'b0;
      init_rom_addr  <= '0;
      req_done       <= '0;
      req_rdata      <= '0;
      req_err        <= 1'b0;
      codec_rd_en    <= 1'b0;
      codec_wr_en    <= 1'b0;
      codec_reg_addr <= '0;
      codec_data_in  <= '0;
    end else begin
      codec_rd_en <= 1'b0;
      codec_wr_en <= 1'b0;
      req_done    <= '0;
      if (init_start) init_pend <= 1'b1;

      case (state)
        S_POR: begin
          if (cnt >= POR_LIM) begin
            state    <= S_FETCH;
            cnt      <= '0;
            fetch_ph <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // ROM data lags the address by one cycle, so each entry takes two FETCH cycles.
        S_FETCH: begin
          if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            fetch_ph <= 1'b0;
            if (init_rom_data[15:8] == 8'hFF || idx >= LEN) begin
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              cur_addr <= init_rom_data[15:8];
              cur_data <= init_rom_data[7:0];
              cur_wr   <= 1'b1;
              cur_init <= 1'b1;
              state    <= S_ISSUE;
            end
          end
        end
        S_IDLE: begin
          if (init_pend) begin
            init_pend     <= 1'b0;
            init_done     <= 1'b0;
            init_error    <= 1'b0;
            idx           <= '0;
            init_rom_addr <= '0;
            fetch_ph      <= 1'b0;
            state         <= S_FETCH;
          end else if (init_done && req_any != 2'b00) begin
            gnt      <= pick;
            last_gnt <= pick;
            cur_addr <= pick ? req_addr[15:8] : req_addr[7:0];
            cur_data <= pick ? req_wdata[15:8] : req_wdata[7:0];
            cur_wr   <= req_wr[pick];
            cur_init <= 1'b0;
            rdata_q  <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!controller_busy) begin
            codec_rd_en    <= ~cur_wr;
            codec_wr_en    <= cur_wr;
            codec_reg_addr <= cur_addr;
            codec_data_in  <= cur_data;
            cnt            <= '0;
            err            <= 1'b0;
            state          <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (controller_busy) begin
            cnt   <= '0;
            state <= S_WAIT_LO;
          end else if (cnt >= SW_LIM) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (codec_data_out_valid && !cur_wr) rdata_q <= codec_data_out;
          if (!controller_busy) begin
            err   <= missed_ack;
            state <= S_DONE;
          end else if (cnt >= TO_LIM) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (cur_init) begin
            init_error    <= init_error | err;
            idx           <= idx_nxt;
            init_rom_addr <= idx_nxt[3:0];
            fetch_ph      <= 1'b0;
            state         <= S_FETCH;
          end else begin
            req_done  <= gnt ? 2'b10 : 2'b01;
            req_err   <= err;
            req_rdata <= cur_wr ? 8'h00 : rdata_q;
            state     <= S_IDLE;
          end
        end
        default: state <= S_POR;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_cfg_arbiter.sv
// Bench for codec_cfg_arbiter: behavioural CODEC/ROM models plus a register shadow scoreboard.
module tb_codec_cfg_arbiter;
  localparam int INIT_LEN = 10;
  localparam int POR_D    = 30;
  localparam int SW       = 4;
  localparam int TO       = 60;
  localparam int BUSY_LEN = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_start;
  logic        init_done, init_error;
  logic [3:0]  init_rom_addr;
  logic [15:0] init_rom_data;
  logic [1:0]  req_rd, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic [1:0]  req_done;
  logic [7:0]  req_rdata;
  logic        req_err;
  logic        codec_rd_en, codec_wr_en;
  logic [7:0]  codec_reg_addr, codec_data_in;
  logic [7:0]  codec_data_out;
  logic        codec_data_out_valid;
  logic        controller_busy;
  logic        missed_ack;

  codec_cfg_arbiter #(
    .INIT_LEN(INIT_LEN), .POR_DELAY(POR_D), .START_WAIT(SW), .XFER_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .init_done(init_done), .init_error(init_error),
    .init_rom_addr(init_rom_addr), .init_rom_data(init_rom_data),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_err(req_err),
    .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
    .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
    .codec_data_out(codec_data_out), .codec_data_out_valid(codec_data_out_valid),
    .controller_busy(controller_busy), .missed_ack(missed_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] rom [16];
  always @(posedge clk) init_rom_data <= rom[init_rom_addr];

  // CODEC model: register file behind the enable handshake; mode 0 normal, 1 busy never rises, 2 busy stuck.
  int         mode = 0;
  bit         nack_en = 1'b0;
  logic [7:0] nack_addr = 8'h00;
  logic [7:0] cdc_regs [256];
  bit         mdl_init = 1'b0;
  int         busy_left = 0;
  bit         cur_nack = 1'b0;
  int         en_cyc_q[$];
  logic [7:0] en_addr_q[$];
  logic [7:0] en_data_q[$];
  bit         en_wr_q[$];
  int         overlap_cnt = 0;
  int         en_while_busy = 0;

  always @(negedge clk) begin
    if (!mdl_init) begin
      for (int i = 0; i < 256; i++) cdc_regs[i] = 8'(i + 3);
      mdl_init = 1'b1;
    end
    if (!reset) begin
      controller_busy      = 1'b0;
      codec_data_out_valid = 1'b0;
      codec_data_out       = 8'h00;
      missed_ack           = 1'b0;
      busy_left            = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          controller_busy = 1'b0;
          missed_ack      = cur_nack;
        end
      end else if (controller_busy && mode != 2) begin
        controller_busy = 1'b0;
      end
      if (codec_rd_en && codec_wr_en) overlap_cnt++;
      if (codec_rd_en || codec_wr_en) begin
        if (controller_busy) en_while_busy++;
        en_cyc_q.push_back(cyc);
        en_addr_q.push_back(codec_reg_addr);
        en_data_q.push_back(codec_data_in);
        en_wr_q.push_back(codec_wr_en);
        codec_data_out_valid = 1'b0;
        if (mode == 0) begin
          controller_busy = 1'b1;
          busy_left       = BUSY_LEN;
          missed_ack      = 1'b0;
          cur_nack        = nack_en && codec_wr_en && (codec_reg_addr == nack_addr);
          if (codec_wr_en) begin
            cdc_regs[codec_reg_addr] = codec_data_in;
          end else begin
            codec_data_out       = cdc_regs[codec_reg_addr];
            codec_data_out_valid = 1'b1;
          end
        end else if (mode == 2) begin
          controller_busy = 1'b1;
          busy_left       = 0;
        end
      end
    end
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_regs [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (init_done) begin ok = 1'b1; break; end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_txn(input int c, input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output bit er, output int dcyc);
    bit ok = 1'b0;
    req_addr[c*8 +: 8]  = a;
    req_wdata[c*8 +: 8] = d;
    req_wr[c] = wr;
    req_rd[c] = ~wr;
    rd = 8'h00; er = 1'b0; dcyc = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      if (req_done != 2'b00) begin ok = 1'b1; break; end
    end
    chk("txn_done_seen", 32'(ok), 32'd1);
    if (ok) begin
      chk("txn_done_onehot", 32'(req_done), 32'(2'b01 << c));
      rd = req_rdata; er = req_err; dcyc = cyc;
    end
    req_wr[c] = 1'b0;
    req_rd[c] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, a, d, d0, d1;
    bit er, ok, any_done;
    int dc, n0, rel_cyc, last_g, exp_g, c;
    bit wr;

    reset = 1'b1; init_start = 1'b0;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) exp_regs[i] = 8'(i + 3);
    for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
    for (int i = 0; i < 3; i++) rom[i] = {8'h20 + 8'(i * 16) + 8'($urandom_range(0, 15)), 8'($urandom)};
    rom[3] = 16'hFF00;

    // Reset state and init replay
    #2 reset = 1'b0;
    repeat (3) step();
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_init_error", 32'(init_error), 0);
    chk("rst_rom_addr", 32'(init_rom_addr), 0);
    chk("rst_en", 32'({codec_rd_en, codec_wr_en}), 0);
    chk("rst_req_done", 32'(req_done), 0);
    chk("rst_reg_addr", 32'(codec_reg_addr), 0);
    @(negedge clk) reset = 1'b1;
    rel_cyc = cyc;
    wait_init("init_done_after_por");
    chk("init_wr_count", 32'(en_wr_q.size()), 3);
    chk("por_delay_respected", 32'((en_cyc_q.size() > 0) && (en_cyc_q[0] - rel_cyc >= POR_D)), 1);
    for (int i = 0; i < 3 && i < en_wr_q.size(); i++) begin
      chk("init_is_write", 32'(en_wr_q[i]), 1);
      chk("init_addr", 32'(en_addr_q[i]), 32'(rom[i][15:8]));
      chk("init_data", 32'(en_data_q[i]), 32'(rom[i][7:0]));
      exp_regs[rom[i][15:8]] = rom[i][7:0];
    end
    chk("init_error_clean", 32'(init_error), 0);

    // Directed client0 read of register 7
    n0 = en_wr_q.size();
    do_txn(0, 1'b0, 8'h07, 8'h00, rd, er, dc);
    chk("rd07_pulses", 32'(en_wr_q.size()), 32'(n0 + 1));
    if (en_wr_q.size() > n0) begin
      chk("rd07_is_read", 32'(en_wr_q[n0]), 0);
      chk("rd07_addr", 32'(en_addr_q[n0]), 32'h07);
    end
    chk("rd07_rdata", 32'(rd), 32'h0A);
    chk("rd07_err", 32'(er), 0);
    last_g = 0;

    // Random single-client writes and reads against the shadow
    for (int k = 0; k < 10; k++) begin
      c  = $urandom_range(0, 1);
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom);
      d  = 8'($urandom);
      do_txn(c, wr, a, d, rd, er, dc);
      chk("rand_rdata", 32'(rd), wr ? 32'd0 : 32'(exp_regs[a]));
      chk("rand_err", 32'(er), 0);
      if (wr) exp_regs[a] = d;
      last_g = c;
    end

    // Both clients write continuously: grants alternate starting with the other client
    d0 = 8'($urandom); d1 = 8'($urandom);
    req_addr = {8'h51, 8'h50}; req_wdata = {d1, d0};
    n0 = en_wr_q.size();
    exp_g = 1 - last_g;
    req_wr = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
        step();
        if (req_done != 2'b00) begin ok = 1'b1; break; end
      end
      chk("rr_done_seen", 32'(ok), 1);
      if (k == 3) req_wr = 2'b00;
      chk("rr_grant", 32'(req_done), 32'(2'b01 << exp_g));
      chk("rr_err", 32'(req_err), 0);
      chk("rr_rdata_zero", 32'(req_rdata), 0);
      last_g = exp_g;
      exp_g = 1 - exp_g;
    end
    repeat (30) step();
    chk("rr_pulse_count", 32'(en_wr_q.size()), 32'(n0 + 4));
    exp_regs[8'h50] = d0; exp_regs[8'h51] = d1;
    do_txn(1, 1'b0, 8'h51, 8'h00, rd, er, dc);
    chk("rr_readback", 32'(rd), 32'(d1));
    last_g = 1;

    // Init rerun with a NACK on the second entry
    nack_addr = rom[1][15:8]; nack_en = 1'b1;
    n0 = en_wr_q.size();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    step();
    chk("rerun_clears_done", 32'(init_done), 0);
    wait_init("rerun_init_done");
    nack_en = 1'b0;
    chk("rerun_error", 32'(init_error), 1);
    chk("rerun_wr_count", 32'(en_wr_q.size()), 32'(n0 + 3));
    if (en_wr_q.size() >= n0 + 3)
      chk("rerun_entry3_issued", 32'(en_addr_q[n0 + 2]), 32'(rom[2][15:8]));

    // Busy never rises: error reported 6 cycles after the enable
    mode = 1;
    n0 = en_wr_q.size();
    do_txn(1, 1'b1, 8'h60, 8'h5A, rd, er, dc);
    chk("norise_err", 32'(er), 1);
    if (en_cyc_q.size() > n0) chk("norise_latency", 32'(dc - en_cyc_q[n0]), 6);
    mode = 0;
    repeat (2) step();

    // Busy stuck high: error after the transfer timeout
    mode = 2;
    n0 = en_wr_q.size();
    do_txn(0, 1'b0, 8'h61, 8'h00, rd, er, dc);
    chk("stuck_err", 32'(er), 1);
    if (en_cyc_q.size() > n0)
      chk("stuck_latency_range", 32'((dc - en_cyc_q[n0] >= TO) && (dc - en_cyc_q[n0] <= TO + 4)), 1);
    mode = 0;
    repeat (3) step();

    // Reset in the middle of a read
    n0 = en_wr_q.size();
    req_addr[7:0] = 8'h07; req_rd[0] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (en_wr_q.size() > n0) begin ok = 1'b1; break; end
    end
    chk("midxfer_started", 32'(ok), 1);
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    chk("arst_en", 32'({codec_rd_en, codec_wr_en}), 0);
    chk("arst_outputs", 32'({req_done, req_err, init_done, init_error}), 0);
    chk("arst_reg_addr", 32'(codec_reg_addr), 0);
    chk("arst_rdata", 32'(req_rdata), 0);
    req_rd = 2'b00;
    any_done = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      if (req_done != 2'b00) any_done = 1'b1;
    end
    reset = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      step();
      if (req_done != 2'b00) any_done = 1'b1;
      if (init_done) begin ok = 1'b1; break; end
    end
    chk("post_reset_init_done", 32'(ok), 1);
    chk("post_reset_no_done", 32'(any_done), 0);
    chk("post_reset_pulses", 32'(en_wr_q.size()), 32'(n0 + 1 + 3));
    chk("post_reset_init_error", 32'(init_error), 0);

    chk("rd_wr_overlap", 32'(overlap_cnt), 0);
    chk("enable_while_busy", 32'(en_while_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
